fetch_ctrl: RTL and testbench

Instruction-fetch controller that drives the program counter register and reads the current PC back. It issues word reads to instruction memory at the current PC and latches the returned instruction for the decode stage. It then supplies the next PC value and a one-cycle load strobe to the PC register: PC+4 for sequential flow, or a redirect target for taken branches and jumps. It sits between the PC register, instruction memory and the multicycle control path, and owns the sequencing of every PC update.

---
 rtl/fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_ctrl_if.sv | 42 ++++
 rtl/fetch_wait_counter.sv | 45 ++++
 rtl/fetch_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch controller: word helpers and the
// 2-bit fetch state encodings.
package fetch_ctrl_pkg;

    typedef logic [31:0] word_t;

    localparam word_t WORD_ZERO = 32'h0000_0000;
    localparam word_t WORD_FOUR = 32'h0000_0004;

    localparam logic [1:0] FETCH_IDLE    = 2'b00;
    localparam logic [1:0] FETCH_FETCH   = 2'b01;
    localparam logic [1:0] FETCH_DELIVER = 2'b10;
    localparam logic [1:0] FETCH_ERROR   = 2'b11;

    // Wide enough for the largest supported wait limit (255).
    localparam int WAIT_CNT_W = 8;

    // Sequential successor; wraps 32'hFFFF_FFFC to zero.
    function automatic word_t pc_seq(input word_t pc);
        return pc + WORD_FOUR;
    endfunction

    function automatic logic is_word_aligned(input word_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port plus the decode-side instruction/redirect
// handshake. master = fetch controller, slave = memory/decode side.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic  mem_req;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_rdata;

    word_t instr;
    logic  instr_valid;
    logic  instr_ready;

    logic  redirect_valid;
    word_t redirect_target;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_target
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_target
    );

endinterface

// File: rtl/fetch_wait_counter.sv
// Saturating wait-cycle counter; limit_next is high when one more increment
// would bring the count to LIMIT.
module fetch_wait_counter
    import fetch_ctrl_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic limit_next
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT_W = WAIT_CNT_W'(LIMIT);
    localparam logic [WAIT_CNT_W-1:0] ONE_W   = WAIT_CNT_W'(1);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;
    logic [WAIT_CNT_W-1:0] cnt_plus;

    assign cnt_plus = cnt_q + ONE_W;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_plus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of inc so the controller can use it in the same cycle
    // it decides to increment without forming a combinational loop.
    assign limit_next = (cnt_plus == LIMIT_W);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: reads memory at pc_cur, latches the word for
// decode and sequences PC updates. Optional macro FETCH_ALIGN_CHECK_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  word_t        pc_cur,
    output word_t        pc_next,
    output logic         pc_load,
    output logic         fault,
    fetch_ctrl_if.master bus
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    word_t      instr_q;
    word_t      instr_d;

    logic in_fetch;
    logic in_deliver;
    logic misaligned;
    logic wait_clr;
    logic wait_inc;
    logic wait_limit_next;

    assign in_fetch   = (state_q == FETCH_FETCH);
    assign in_deliver = (state_q == FETCH_DELIVER);

`ifdef FETCH_ALIGN_CHECK_EN
    // pc_cur is stable for the whole FETCH, so checking every FETCH cycle
    // is the same as checking on entry.
    assign misaligned = in_fetch && !is_word_aligned(pc_cur);
`else
    assign misaligned = 1'b0;
`endif

    fetch_wait_counter #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (wait_clr),
        .inc        (wait_inc),
        .limit_next (wait_limit_next)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_next  = pc_seq(pc_cur);
        pc_load  = 1'b0;
        wait_clr = 1'b0;
        wait_inc = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (en) begin
                    state_d = FETCH_FETCH;
                end
            end
            FETCH_FETCH: begin
                if (misaligned) begin
                    state_d = FETCH_ERROR;
                end else if (bus.mem_ack) begin
                    // PC register and instr update on the same edge.
                    instr_d  = bus.mem_rdata;
                    pc_load  = 1'b1;
                    wait_clr = 1'b1;
                    state_d  = FETCH_DELIVER;
                end else begin
                    wait_inc = 1'b1;
                    if (wait_limit_next) begin
                        state_d = FETCH_ERROR;
                    end
                end
            end
            FETCH_DELIVER: begin
                if (bus.instr_ready) begin
                    if (bus.redirect_valid) begin
                        pc_next = bus.redirect_target;
                        pc_load = 1'b1;
                    end
                    state_d = en ? FETCH_FETCH : FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            instr_q <= WORD_ZERO;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decode from registered state, so rst drops mem_req at once.
    assign bus.mem_req     = in_fetch && !misaligned;
    assign bus.mem_addr    = pc_cur;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = in_deliver;
    assign fault           = (state_q == FETCH_ERROR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a flag/queue-level reference model and
// a per-cycle output comparison.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int WAIT_LIMIT = 15;

    logic  clk = 1'b0;
    logic  rst;
    logic  en;
    word_t pc_cur;
    word_t pc_next;
    logic  pc_load;
    logic  fault;
    logic  pc_set;
    word_t pc_set_val;

    int tests = 0;
    int fails = 0;
    int reqs;
    int loads;
    int lows;

    fetch_ctrl_if bus();

    fetch_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .pc_cur  (pc_cur),
        .pc_next (pc_next),
        .pc_load (pc_load),
        .fault   (fault),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // External PC register, with a bench override used to plant test PCs.
    always @(posedge clk) begin
        if (pc_set) pc_cur <= pc_set_val;
        else if (pc_load) pc_cur <= pc_next;
    end

    function automatic logic align_bad(input word_t a);
`ifdef FETCH_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00);
`else
        return (a != a);
`endif
    endfunction

    // Reference model: "fetch outstanding", "instruction held", "dead" flags.
    logic  m_busy;
    logic  m_have;
    logic  m_dead;
    int    m_waits;
    word_t m_instr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_have  <= 1'b0;
            m_dead  <= 1'b0;
            m_waits <= 0;
            m_instr <= 32'h0;
        end else if (!m_dead) begin
            if (m_busy) begin
                if (align_bad(pc_cur)) begin
                    m_busy <= 1'b0;
                    m_dead <= 1'b1;
                end else if (bus.mem_ack) begin
                    m_instr <= bus.mem_rdata;
                    m_busy  <= 1'b0;
                    m_have  <= 1'b1;
                    m_waits <= 0;
                end else begin
                    m_waits <= m_waits + 1;
                    if (m_waits + 1 == WAIT_LIMIT) begin
                        m_busy <= 1'b0;
                        m_dead <= 1'b1;
                    end
                end
            end else if (m_have) begin
                if (bus.instr_ready) begin
                    m_have <= 1'b0;
                    m_busy <= en;
                end
            end else begin
                m_busy <= en;
            end
        end
    end

    logic  e_req;
    logic  e_redir;
    logic  e_load;
    word_t e_next;
    assign e_req   = m_busy && !m_dead && !align_bad(pc_cur);
    assign e_redir = m_have && bus.instr_ready && bus.redirect_valid;
    assign e_load  = (e_req && bus.mem_ack) || e_redir;
    assign e_next  = e_redir ? bus.redirect_target : pc_cur + 32'd4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_fault",   {31'b0, fault},           {31'b0, m_dead});
        chk("m_req",     {31'b0, bus.mem_req},     {31'b0, e_req});
        chk("m_valid",   {31'b0, bus.instr_valid}, {31'b0, m_have});
        chk("m_instr",   bus.instr,                m_instr);
        chk("m_load",    {31'b0, pc_load},         {31'b0, e_load});
        chk("m_pc_next", pc_next,                  e_next);
        if (e_req) chk("m_addr", bus.mem_addr, pc_cur);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        pc_set = 1'b1;
        pc_set_val = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;

        repeat (2) @(posedge clk);
        settle();
        chk("rst_req",   {31'b0, bus.mem_req},     32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instr,                32'h0);
        chk("rst_load",  {31'b0, pc_load},         32'h0);
        chk("rst_fault", {31'b0, fault},           32'h0);
        step();
        rst = 1'b0;
        pc_set = 1'b0;

        // Zero-wait fetch at PC 0.
        en = 1'b1;
        settle();
        chk("idle_req", {31'b0, bus.mem_req}, 32'h0);
        step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h8C010004;
        settle();
        chk("t1_req",  {31'b0, bus.mem_req}, 32'h1);
        chk("t1_addr", bus.mem_addr,         32'h0);
        chk("t1_load", {31'b0, pc_load},     32'h1);
        chk("t1_next", pc_next,              32'h4);
        step();
        bus.mem_ack = 1'b0;
        settle();
        chk("t1_instr", bus.instr,                32'h8C010004);
        chk("t1_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("t1_pc",    pc_cur,                   32'h4);

        // Accept without redirect, then three wait cycles before the ack.
        bus.instr_ready = 1'b1;
        settle();
        chk("t2_acc_load", {31'b0, pc_load}, 32'h0);
        step();
        bus.instr_ready = 1'b0;
        reqs = 0;
        loads = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = (i == 3);
            bus.mem_rdata = 32'h0000_1111;
            settle();
            if (bus.mem_req) reqs++;
            if (pc_load) loads++;
            chk("t2_addr", bus.mem_addr, 32'h4);
            step();
        end
        bus.mem_ack = 1'b0;
        settle();
        chk("t2_reqs",  reqs,      32'd4);
        chk("t2_loads", loads,     32'd1);
        chk("t2_instr", bus.instr, 32'h0000_1111);
        chk("t2_pc",    pc_cur,    32'h8);

        // Redirect on accept.
        step();
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h40;
        settle();
        chk("t3_load", {31'b0, pc_load}, 32'h1);
        chk("t3_next", pc_next,          32'h40);
        step();
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hABCD0123;
        settle();
        chk("t3_addr", bus.mem_addr,         32'h40);
        chk("t3_req",  {31'b0, bus.mem_req}, 32'h1);
        chk("t3_seq",  pc_next,              32'h44);
        step();
        bus.mem_ack = 1'b0;

        // Consumer stalls five cycles with redirect_valid high.
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h80;
        loads = 0;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (pc_load) loads++;
            if (!bus.instr_valid) lows++;
            step();
        end
        chk("t4_loads", loads, 32'd0);
        chk("t4_lows",  lows,  32'd0);
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        en = 1'b0;
        settle();
        chk("t4_acc_load", {31'b0, pc_load}, 32'h0);
        step();
        bus.redirect_valid = 1'b1;
        settle();
        chk("t4_pc",        pc_cur,                   32'h44);
        chk("idle_redir",   {31'b0, pc_load},         32'h0);
        chk("idle_valid",   {31'b0, bus.instr_valid}, 32'h0);
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b0;

        // PC wrap at the top of the address space.
        pc_set = 1'b1;
        pc_set_val = 32'hFFFF_FFFC;
        step();
        pc_set = 1'b0;
        en = 1'b1;
        step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h5;
        settle();
        chk("t6_addr", bus.mem_addr,     32'hFFFF_FFFC);
        chk("t6_load", {31'b0, pc_load}, 32'h1);
        chk("t6_next", pc_next,          32'h0);
        step();
        bus.mem_ack = 1'b0;
        bus.instr_ready = 1'b1;
        settle();
        chk("t6_pc", pc_cur, 32'h0);
        step();
        bus.instr_ready = 1'b0;

        // Memory never answers: bus fault after WAIT_LIMIT fetch cycles.
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (fault) break;
            if (bus.mem_req) reqs++;
            step();
        end
        chk("t5_reqs",  reqs,            WAIT_LIMIT);
        chk("t5_fault", {31'b0, fault},  32'h1);
        bus.mem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            settle();
            if (!fault || bus.mem_req || pc_load) lows++;
        end
        chk("t5_sticky", lows, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_fault", {31'b0, fault},           32'h0);
        chk("t5_rst_req",   {31'b0, bus.mem_req},     32'h0);
        chk("t5_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("t5_rst_instr", bus.instr,                32'h0);
        chk("t5_rst_load",  {31'b0, pc_load},         32'h0);
        step();
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        en = 1'b1;

        // Asynchronous reset in the middle of a FETCH.
        step();
        settle();
        chk("t7_req_before", {31'b0, bus.mem_req}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t7_req_async", {31'b0, bus.mem_req}, 32'h0);
        step();
        rst = 1'b0;
        en = 1'b0;
        settle();
        chk("t7_idle_req", {31'b0, bus.mem_req}, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC: no request, fault one cycle later.
        pc_set = 1'b1;
        pc_set_val = 32'h2;
        step();
        pc_set = 1'b0;
        en = 1'b1;
        step();
        settle();
        chk("t8_req", {31'b0, bus.mem_req}, 32'h0);
        step();
        settle();
        chk("t8_fault", {31'b0, fault}, 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 1'b0;
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
